dm_port_arbiter: RTL

//  Shares the single-port synchronous data memory (1-cycle registered read) between two requesters:

---
 rtl/dm_arb_pkg.sv | 26 ++
 rtl/dm_arb_starve_ctr.sv | 30 +++
 rtl/dm_port_arbiter.sv | 139 +++++++++++++
 3 files changed

// File: rtl/dm_arb_pkg.sv
// Shared types for the data-memory port arbiter: FSM state encoding, owner codes and port indices.
// State encoding equals the owner code so the registered state can be exported directly.
package dm_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_LOCK0 = 2'b01,
    ST_LOCK1 = 2'b10
  } arb_state_t;

  localparam logic [1:0] OWNER_NONE = 2'b00;
  localparam logic [1:0] OWNER_P0   = 2'b01;
  localparam logic [1:0] OWNER_P1   = 2'b10;

  localparam logic P0_IDX = 1'b0;
  localparam logic P1_IDX = 1'b1;

  function automatic logic [1:0] owner_of(input arb_state_t s);
    case (s)
      ST_LOCK0: return OWNER_P0;
      ST_LOCK1: return OWNER_P1;
      default:  return OWNER_NONE;
    endcase
  endfunction

endpackage

// File: rtl/dm_arb_starve_ctr.sv
// Port-1 wait counter: counts cycles port 1 is requesting but not granted, saturating at MAX_WAIT.
// o_starved flags that port 1 has waited the full limit and should win the next idle arbitration.
module dm_arb_starve_ctr #(
  parameter int MAX_WAIT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic i_req,
  input  logic i_gnt,
  output logic o_starved
);

  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] LP_MAX = CW'(MAX_WAIT);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (!i_req || i_gnt) begin
      r_cnt <= '0;
    end else if (r_cnt != LP_MAX) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_starved = (r_cnt == LP_MAX);

endmodule

// File: rtl/dm_port_arbiter.sv
// Two-port arbiter in front of a single-port synchronous data memory (P0 = MEM stage, P1 = loader/debug).
// Optional port-1 starvation guard is enabled with `define DM_ARB_STARVE_GUARD_EN.
module dm_port_arbiter
  import dm_arb_pkg::*;
#(
  parameter int MEM_BITS = 12,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                p0_req,
  input  logic                p0_we,
  input  logic                p0_lock,
  input  logic [31:0]         p0_addr,
  input  logic [DATA_W-1:0]   p0_wdata,
  output logic                p0_gnt,
  output logic                p0_rvalid,
  output logic [DATA_W-1:0]   p0_rdata,
  input  logic                p1_req,
  input  logic                p1_we,
  input  logic                p1_lock,
  input  logic [31:0]         p1_addr,
  input  logic [DATA_W-1:0]   p1_wdata,
  output logic                p1_gnt,
  output logic                p1_rvalid,
  output logic [DATA_W-1:0]   p1_rdata,
  output logic [MEM_BITS-1:0] dm_addr,
  output logic [DATA_W-1:0]   dm_wdata,
  output logic                dm_we,
  input  logic [DATA_W-1:0]   dm_rdata,
  output logic [1:0]          owner
);

  // Handshake: pN_req is held until pN_gnt is seen high in the same cycle; that cycle is the
  // access. A granted read returns exactly one cycle later on pN_rvalid with pN_rdata.

  arb_state_t        r_state;
  arb_state_t        w_next;
  logic [1:0]        w_gnt;
  logic              w_p1_force;
  logic              r_rd_pend;
  logic              r_rd_port;
  logic [MEM_BITS-1:0] w_addr;
  logic [DATA_W-1:0]   w_wdata;
  logic              w_we;
  logic              w_unused_addr;

`ifdef DM_ARB_STARVE_GUARD_EN
  dm_arb_starve_ctr #(
    .MAX_WAIT (MAX_WAIT)
  ) u_starve (
    .clk       (clk),
    .rst       (rst),
    .i_req     (p1_req),
    .i_gnt     (w_gnt[P1_IDX]),
    .o_starved (w_p1_force)
  );
`else
  localparam int LP_UNUSED_MAX_WAIT = MAX_WAIT;
  assign w_p1_force = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_gnt[P0_IDX] && p0_lock)      w_next = ST_LOCK0;
        else if (w_gnt[P1_IDX] && p1_lock) w_next = ST_LOCK1;
      end
      ST_LOCK0: if (!p0_req || !p0_lock) w_next = ST_IDLE;
      ST_LOCK1: if (!p1_req || !p1_lock) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // Grant decode; a locked owner excludes the other port even when the guard has fired.
  always_comb begin
    w_gnt = 2'b00;
    case (r_state)
      ST_IDLE: begin
        if (w_p1_force && p1_req) w_gnt[P1_IDX] = 1'b1;
        else if (p0_req)          w_gnt[P0_IDX] = 1'b1;
        else if (p1_req)          w_gnt[P1_IDX] = 1'b1;
      end
      ST_LOCK0: w_gnt[P0_IDX] = p0_req;
      ST_LOCK1: w_gnt[P1_IDX] = p1_req;
      default:  w_gnt = 2'b00;
    endcase
  end

  always_comb begin
    w_addr  = '0;
    w_wdata = '0;
    w_we    = 1'b0;
    if (w_gnt[P0_IDX]) begin
      w_addr  = p0_addr[MEM_BITS-1:0];
      w_wdata = p0_wdata;
      w_we    = p0_we;
    end else if (w_gnt[P1_IDX]) begin
      w_addr  = p1_addr[MEM_BITS-1:0];
      w_wdata = p1_wdata;
      w_we    = p1_we;
    end
  end

  // Read-return tag: which port's read is being answered by dm_rdata this cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_pend <= 1'b0;
      r_rd_port <= P0_IDX;
    end else begin
      r_rd_pend <= (w_gnt[P0_IDX] && !p0_we) || (w_gnt[P1_IDX] && !p1_we);
      r_rd_port <= w_gnt[P1_IDX] ? P1_IDX : P0_IDX;
    end
  end

  assign w_unused_addr = ^{p0_addr[31:MEM_BITS], p1_addr[31:MEM_BITS]};

  assign p0_gnt    = w_gnt[P0_IDX];
  assign p1_gnt    = w_gnt[P1_IDX];
  assign dm_addr   = w_addr;
  assign dm_wdata  = w_wdata;
  assign dm_we     = w_we;
  assign p0_rvalid = r_rd_pend && (r_rd_port == P0_IDX);
  assign p1_rvalid = r_rd_pend && (r_rd_port == P1_IDX);
  assign p0_rdata  = dm_rdata;
  assign p1_rdata  = dm_rdata;
  assign owner     = owner_of(r_state);

endmodule
